inputc_mvc: RTL and testbench
=============================

// Module: inputc_mvc
// PURPOSE
//  Parametrised router input channel: NVCH virtual channels, each with a DEPTH-flit FIFO.
//  Performs XY route computation on head flits and per-VC wormhole state tracking.
//  Runs round-robin VC selection and issues one switch request per cycle to the allocator.
//  Sits between the upstream link and the crossbar; one instance per physical input port.
// PARAMETERS
//  DATAW    64  flit width in bits; flit[DATAW-1:DATAW-2]=type, flit[XW+YW+1:2]={dstY,dstX}
//  NVCH     2   virtual channels per port (>=1); VCW=max(1,$clog2(NVCH))
//  DEPTH    4   flits per VC FIFO (power of 2, >=2)
//  NPORT    5   router ports; PORTW=$clog2(NPORT)
//  XW/YW    2/2 destination coordinate widths
//  MY_XPOS  0   this router X; MY_YPOS 0 this router Y
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst_       in   1              synchronous reset, active-low
//  idata      in   DATAW          incoming flit
//  ivalid     in   1              idata valid this cycle
//  ivch       in   VCW            target VC of incoming flit
//  oack       out  NVCH           one-cycle credit pulse per dequeued flit, per VC
//  ordy       out  NVCH           VC FIFO not full
//  olck       out  NVCH           VC holds a packet (head seen, tail not yet dequeued)
//  odata      out  DATAW          flit to crossbar
//  ovalid     out  1              odata valid
//  ovch       out  VCW            output VC (= input VC; VC index preserved)
//  irdy       in   NPORT*NVCH     downstream VC has credit, index port*NVCH+vc
//  ilck       in   NPORT*NVCH     downstream VC locked by another packet
//  grt        in   NPORT          switch grant, one-hot, same cycle as req
//  port       out  PORTW          requested output port
//  req        out  1              switch request
// BEHAVIOUR
//  Reset (rst_=0 at edge): all FIFOs empty, FSMs IDLE, RR pointer 0.
//   Output reset values: oack=0, ordy=all 1, olck=0, odata=0, ovalid=0, ovch=0, req=0, port=0.
//  Flit types: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet).
//  Write: ivalid & ordy[ivch] -> enqueue at edge. Write to a full VC is dropped and
//   flagged by a sim-only assertion; a same-cycle dequeue does not make room.
//  Per-VC FSM:
//   IDLE -> ROUTE when front flit is head/head+tail.
//   ROUTE (1 cycle) registers out-port by XY: dstX>MY_XPOS E(1), < W(2), else dstY>MY_YPOS
//    N(3), < S(4), else LOCAL(0); -> ACTIVE. Non-head at front in IDLE: sim assertion, flit held.
//   ACTIVE -> IDLE when tail/head+tail is dequeued.
//  Eligible VC: ACTIVE, FIFO non-empty, irdy[p*NVCH+v]=1; if front is head also ilck[..]=0.
//  req/port combinational from RR winner among eligible VCs; RR pointer advances past the
//   winner only when granted.
//  grt[port]&req at edge t: winner dequeued; odata/ovch/ovalid registered valid t+1;
//   oack[v] pulses at t+1. grt without req, or for another port: ignored.
//  Latency: head written at t -> ROUTE t+1 -> req earliest t+2 -> odata t+3.
//   Body flits of an ACTIVE VC stream 1/cycle.
//  olck[v]=1 from ROUTE entry until tail dequeue.
//  Pointers wrap mod DEPTH; count width $clog2(DEPTH)+1 distinguishes full/empty.
//  Reset mid-packet discards all buffered flits; no oack issued for them.
// CONFIGURATION
//  INPUTC_MVC_STATS_EN defined: adds outputs flit_cnt[31:0] (flits dequeued) and
//   stall_cnt[31:0] (cycles with eligible VC but no grant); both wrap, both cleared by reset.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  define.v: flit-type codes, port codes LOCAL/E/W/N/S, field offsets.
//  Sub-module inputc_mvc_fifo (DATAW, DEPTH): push/pop/full/empty/front; one per VC via generate.
//  FSMs, route compute and RR arbiter stay in inputc_mvc.
// TESTING
//  MY=(1,0); head+tail dst=(3,0) on VC0, all irdy=1 -> req=1, port=1 at t+2;
//   grt=00010 -> odata t+3, oack=01.
//  Head dst=(1,2), 2 bodies, tail on VC1 -> port=3, 4 flits on 4 consecutive cycles;
//   olck[1] falls after tail.
//  Fill VC0 with DEPTH flits, no grant -> ordy[0]=0; extra write dropped;
//   after one grant ordy[0]=1 the next cycle.
//  Both VCs active to port 0, grt held -> grants alternate VC0,VC1,VC0; ovch toggles.
//  ilck[E,VC0]=1 with head pending -> req=0 until ilck clears; VC1 still served.
//  rst_=0 mid-packet for one cycle -> all FIFOs empty, olck=0, ordy=all 1; no late oack.

Source files
------------

// File: rtl/inputc_mvc_pkg.sv
// inputc_mvc_pkg: flit-type codes, output-port codes, VC states and XY route helper
package inputc_mvc_pkg;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;
    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_E     = 3'd1;
    localparam logic [2:0] P_W     = 3'd2;
    localparam logic [2:0] P_N     = 3'd3;
    localparam logic [2:0] P_S     = 3'd4;
    localparam int ROUTE_LSB = 2;

    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} vc_state_e;

    // Head and head+tail both carry bit 0; tail and head+tail both carry bit 1.
    function automatic logic is_head(input logic [1:0] ty);
        return ty[0];
    endfunction

    function automatic logic is_tail(input logic [1:0] ty);
        return ty[1];
    endfunction

    function automatic logic [2:0] xy_route(input int dx, input int dy, input int mx, input int my);
        return dx > mx ? P_E : dx < mx ? P_W : dy > my ? P_N : dy < my ? P_S : P_LOCAL;
    endfunction
endpackage

// File: rtl/inputc_mvc_if.sv
// inputc_mvc_if: upstream link and crossbar/allocator signals of one router input channel
interface inputc_mvc_if #(
    parameter int DATAW = 64,
    parameter int NVCH  = 2,
    parameter int NPORT = 5
);
    localparam int VCW   = NVCH > 1 ? $clog2(NVCH) : 1;
    localparam int PORTW = $clog2(NPORT);
    logic [DATAW-1:0]      idata;
    logic                  ivalid;
    logic [VCW-1:0]        ivch;
    logic [NVCH-1:0]       oack;
    logic [NVCH-1:0]       ordy;
    logic [NVCH-1:0]       olck;
    logic [DATAW-1:0]      odata;
    logic                  ovalid;
    logic [VCW-1:0]        ovch;
    logic [NPORT*NVCH-1:0] irdy;
    logic [NPORT*NVCH-1:0] ilck;
    logic [NPORT-1:0]      grt;
    logic [PORTW-1:0]      port;
    logic                  req;

    modport slave (
        input  idata, ivalid, ivch, irdy, ilck, grt,
        output oack, ordy, olck, odata, ovalid, ovch, port, req
    );
    modport master (
        output idata, ivalid, ivch, irdy, ilck, grt,
        input  oack, ordy, olck, odata, ovalid, ovch, port, req
    );
endinterface

// File: rtl/inputc_mvc_fifo.sv
// inputc_mvc_fifo: per-VC flit FIFO; writes to a full FIFO are dropped even if a pop happens the same cycle
module inputc_mvc_fifo #(
    parameter int DATAW = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] din,
    output logic [DATAW-1:0] front,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic wr, rd;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign front = mem[rp];

    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;

    always_ff @(posedge clk)
        if (!rst_) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wr ? wp + AW'(1) : wp;
            rp  <= rd ? rp + AW'(1) : rp;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end

`ifndef SYNTHESIS
    always_ff @(posedge clk)
        if (rst_) assert (!(push && full)) else $warning("inputc_mvc_fifo: write to full VC dropped");
`endif
endmodule

// File: rtl/inputc_mvc.sv
// inputc_mvc: router input channel with per-VC FIFOs, XY routing, wormhole locking and RR switch request
// Defining INPUTC_MVC_STATS_EN adds flit_cnt/stall_cnt statistics outputs.
module inputc_mvc
    import inputc_mvc_pkg::*;
#(
    parameter int DATAW   = 64,
    parameter int NVCH    = 2,
    parameter int DEPTH   = 4,
    parameter int NPORT   = 5,
    parameter int XW      = 2,
    parameter int YW      = 2,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0
) (
    input logic clk,
    input logic rst_,
    inputc_mvc_if.slave bus
`ifdef INPUTC_MVC_STATS_EN
    ,
    output logic [31:0] flit_cnt,
    output logic [31:0] stall_cnt
`endif
);
    localparam int VCW   = NVCH > 1 ? $clog2(NVCH) : 1;
    localparam int PORTW = $clog2(NPORT);
    logic [DATAW-1:0] front [NVCH];
    logic [PORTW-1:0] vport [NVCH];
    vc_state_e st [NVCH];
    logic [NVCH-1:0] full, empty, push, pop, head, tail, elig, lck;
    logic [VCW-1:0] rr, win;
    logic [PORTW-1:0] port_w;
    logic found, deq;

    for (genvar v = 0; v < NVCH; v++) begin : g_vc
        assign push[v] = bus.ivalid && bus.ivch == VCW'(v);
        assign pop[v]  = deq && win == VCW'(v);
        assign head[v] = is_head(front[v][DATAW-1 -: 2]);
        assign tail[v] = is_tail(front[v][DATAW-1 -: 2]);
        assign lck[v]  = st[v] != IDLE;
        // A head still waiting at the front must also find the downstream VC unlocked.
        assign elig[v] = st[v] == ACTIVE && !empty[v] && bus.irdy[int'(vport[v])*NVCH+v]
                         && !(head[v] && bus.ilck[int'(vport[v])*NVCH+v]);

        inputc_mvc_fifo #(.DATAW(DATAW), .DEPTH(DEPTH)) u_fifo (
            .clk(clk), .rst_(rst_), .push(push[v]), .pop(pop[v]), .din(bus.idata),
            .front(front[v]), .full(full[v]), .empty(empty[v])
        );

        always_ff @(posedge clk)
            if (!rst_) begin
                st[v]    <= IDLE;
                vport[v] <= '0;
            end else
                case (st[v])
                    IDLE:    if (!empty[v] && head[v]) st[v] <= ROUTE;
                    ROUTE: begin
                        vport[v] <= PORTW'(xy_route(int'(front[v][ROUTE_LSB +: XW]),
                                                    int'(front[v][ROUTE_LSB+XW +: YW]), MY_XPOS, MY_YPOS));
                        st[v]    <= ACTIVE;
                    end
                    ACTIVE:  if (pop[v] && tail[v]) st[v] <= IDLE;
                    default: st[v] <= IDLE;
                endcase

`ifndef SYNTHESIS
        always_ff @(posedge clk)
            if (rst_ && st[v] == IDLE && !empty[v]) assert (head[v]) else $warning("inputc_mvc: non-head flit at front of idle VC");
`endif
    end

    always_comb begin
        win   = rr;
        found = 1'b0;
        for (int i = 0; i < NVCH; i++) begin
            if (!found && elig[(int'(rr)+i)%NVCH]) begin
                win   = VCW'((int'(rr)+i)%NVCH);
                found = 1'b1;
            end
        end
    end

    assign port_w   = found ? vport[win] : '0;
    assign deq      = found && bus.grt[port_w];
    assign bus.port = port_w;
    assign bus.req  = found;
    assign bus.ordy = ~full;
    assign bus.olck = lck;

    always_ff @(posedge clk)
        if (!rst_) begin
            rr         <= '0;
            bus.odata  <= '0;
            bus.ovch   <= '0;
            bus.ovalid <= 1'b0;
            bus.oack   <= '0;
        end else begin
            rr         <= deq ? VCW'((int'(win)+1)%NVCH) : rr;
            bus.odata  <= deq ? front[win] : bus.odata;
            bus.ovch   <= deq ? win : bus.ovch;
            bus.ovalid <= deq;
            bus.oack   <= deq ? NVCH'(1) << win : '0;
        end

`ifdef INPUTC_MVC_STATS_EN
    always_ff @(posedge clk)
        if (!rst_) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            flit_cnt  <= flit_cnt + 32'(deq);
            stall_cnt <= stall_cnt + 32'(found && !deq);
        end
`endif
endmodule

// File: tb/tb_inputc_mvc.sv
// tb_inputc_mvc: directed vectors for inputc_mvc (MY=(1,0)) checked against a queue-based packet model every cycle
module tb_inputc_mvc;
    localparam int DATAW = 64;
    localparam int NVCH  = 2;
    localparam int DEPTH = 4;
    localparam int NPORT = 5;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int nvec = 0, nfail = 0;
    always #5 clk = ~clk;

    inputc_mvc_if #(.DATAW(DATAW), .NVCH(NVCH), .NPORT(NPORT)) bus();
`ifdef INPUTC_MVC_STATS_EN
    logic [31:0] flit_cnt, stall_cnt;
`endif
    inputc_mvc #(.DATAW(DATAW), .NVCH(NVCH), .DEPTH(DEPTH), .NPORT(NPORT), .XW(2), .YW(2),
                 .MY_XPOS(1), .MY_YPOS(0)) dut (
        .clk(clk), .rst_(rst_), .bus(bus)
`ifdef INPUTC_MVC_STATS_EN
        , .flit_cnt(flit_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // Model: per-VC packet queues, lock/active flags, routed port and RR pointer.
    logic [DATAW-1:0] q [NVCH][$];
    bit lk [NVCH];
    bit act [NVCH];
    int rp [NVCH];
    int rr = 0, m_w = -1, exp_vc = 0;
    bit armed = 0, exp_ov = 0;
    logic [DATAW-1:0] exp_od = '0;
    logic [NVCH-1:0] exp_ack = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
        end
    endtask

    function automatic int route(input logic [DATAW-1:0] f);
        int x, y;
        x = int'(f[3:2]);
        y = int'(f[5:4]);
        if (x > 1) return 1;
        if (x < 1) return 2;
        if (y > 0) return 3;
        return 0;
    endfunction

    function automatic logic [DATAW-1:0] mk(input logic [1:0] ty, input int x, input int y, input int pl);
        return {ty, 56'(pl), 2'(y), 2'(x), 2'b00};
    endfunction

    initial forever begin
        @(negedge clk);
        if (armed) begin
            logic [NVCH-1:0] eo, el;
            int v;
            m_w = -1;
            for (int i = 0; i < NVCH; i++) begin
                v = (rr + i) % NVCH;
                if (m_w < 0 && act[v] && q[v].size() > 0 && bus.irdy[rp[v]*NVCH+v]
                    && !(q[v][0][62] && bus.ilck[rp[v]*NVCH+v])) m_w = v;
                eo[i] = q[i].size() < DEPTH;
                el[i] = lk[i];
            end
            chk("req", bus.req, m_w >= 0);
            if (m_w >= 0) chk("port", bus.port, rp[m_w]);
            chk("ordy", bus.ordy, eo);
            chk("olck", bus.olck, el);
            chk("ovalid", bus.ovalid, exp_ov);
            chk("oack", bus.oack, exp_ack);
            if (exp_ov) begin
                chk("odata", bus.odata, exp_od);
                chk("ovch", bus.ovch, exp_vc);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        if (!rst_) begin
            for (int v = 0; v < NVCH; v++) begin
                q[v].delete();
                lk[v] = 0;
                act[v] = 0;
                rp[v] = 0;
            end
            rr = 0; exp_ov = 0; exp_od = '0; exp_vc = 0; exp_ack = '0; m_w = -1; armed = 1;
        end else if (armed) begin
            bit start [NVCH];
            bit routed [NVCH];
            for (int v = 0; v < NVCH; v++) begin
                start[v]  = !lk[v] && q[v].size() > 0 && q[v][0][62];
                routed[v] = lk[v] && !act[v];
            end
            exp_ov = 0;
            exp_ack = '0;
            if (m_w >= 0 && bus.grt[rp[m_w]]) begin
                exp_ov = 1;
                exp_od = q[m_w][0];
                exp_vc = m_w;
                exp_ack[m_w] = 1'b1;
                if (q[m_w][0][63]) begin
                    lk[m_w] = 0;
                    act[m_w] = 0;
                end
                void'(q[m_w].pop_front());
                rr = (m_w + 1) % NVCH;
            end
            for (int v = 0; v < NVCH; v++) begin
                if (routed[v]) begin
                    act[v] = 1;
                    rp[v] = route(q[v][0]);
                end
                if (start[v]) lk[v] = 1;
            end
            if (bus.ivalid && q[bus.ivch].size() < DEPTH) q[bus.ivch].push_back(bus.idata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [DATAW-1:0] f);
        bus.ivalid = 1'b1;
        bus.ivch = v;
        bus.idata = f;
        tick();
        bus.ivalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATAW-1:0] f, h, b1, b2, t;
        bus.idata = '0; bus.ivalid = 1'b0; bus.ivch = 1'b0;
        bus.irdy = '1; bus.ilck = '0; bus.grt = '0;
        tick(); tick();
        chk("rst_ordy", bus.ordy, 2'b11);
        chk("rst_olck", bus.olck, 2'b00);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_port", bus.port, 3'd0);
        chk("rst_ovalid", bus.ovalid, 1'b0);
        chk("rst_odata", bus.odata, 64'd0);
        chk("rst_oack", bus.oack, 2'b00);
        chk("rst_ovch", bus.ovch, 1'b0);
        rst_ = 1'b1;
        tick();

        // single-flit packet east, latency head->odata of three edges
        f = mk(2'b11, 3, 0, 32'h11);
        send(1'b0, f);
        chk("t1_lck0", bus.olck, 2'b00);
        tick();
        chk("t1_lck1", bus.olck, 2'b01);
        chk("t1_req1", bus.req, 1'b0);
        tick();
        chk("t1_req2", bus.req, 1'b1);
        chk("t1_port", bus.port, 3'd1);
        bus.grt = 5'b00010;
        tick();
        chk("t1_ovalid", bus.ovalid, 1'b1);
        chk("t1_odata", bus.odata, f);
        chk("t1_oack", bus.oack, 2'b01);
        chk("t1_olck", bus.olck, 2'b00);
        bus.grt = '0;
        tick();
        chk("t1_oack_end", bus.oack, 2'b00);

        // four-flit packet north on VC1 streams one flit per cycle
        h = mk(2'b01, 1, 2, 32'h21); b1 = mk(2'b00, 0, 0, 32'h22);
        b2 = mk(2'b00, 0, 0, 32'h23); t = mk(2'b10, 0, 0, 32'h24);
        bus.grt = 5'b01000;
        send(1'b1, h);
        send(1'b1, b1);
        send(1'b1, b2);
        chk("t2_req", bus.req, 1'b1);
        chk("t2_port", bus.port, 3'd3);
        send(1'b1, t);
        chk("t2_head", bus.odata, h);
        chk("t2_ovch", bus.ovch, 1'b1);
        tick();
        chk("t2_b1", bus.odata, b1);
        tick();
        chk("t2_b2", bus.odata, b2);
        chk("t2_lck", bus.olck, 2'b10);
        tick();
        chk("t2_tail", bus.odata, t);
        chk("t2_unlck", bus.olck, 2'b00);
        tick();
        chk("t2_idle", bus.ovalid, 1'b0);
        bus.grt = '0;

        // two VCs to the local port share the switch alternately
        send(1'b0, mk(2'b01, 1, 0, 32'h41));
        send(1'b1, mk(2'b01, 1, 0, 32'h51));
        send(1'b0, mk(2'b00, 0, 0, 32'h42));
        send(1'b1, mk(2'b00, 0, 0, 32'h52));
        send(1'b0, mk(2'b10, 0, 0, 32'h43));
        send(1'b1, mk(2'b10, 0, 0, 32'h53));
        bus.grt = 5'b00001;
        tick();
        chk("t4_vc_a", bus.ovch, 1'b0);
        tick();
        chk("t4_vc_b", bus.ovch, 1'b1);
        tick();
        chk("t4_vc_c", bus.ovch, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_done", bus.olck, 2'b00);
        bus.grt = '0;

        // fill VC0; extra write is dropped; one grant frees a slot
        send(1'b0, mk(2'b01, 1, 0, 32'h61));
        send(1'b0, mk(2'b00, 0, 0, 32'h62));
        send(1'b0, mk(2'b00, 0, 0, 32'h63));
        send(1'b0, mk(2'b00, 0, 0, 32'h64));
        chk("t3_full", bus.ordy, 2'b10);
        send(1'b0, mk(2'b00, 0, 0, 32'h6f));
        chk("t3_still_full", bus.ordy, 2'b10);
        bus.grt = 5'b00001;
        tick();
        chk("t3_room", bus.ordy, 2'b11);
        bus.grt = '0;
        send(1'b0, mk(2'b10, 0, 0, 32'h65));
        bus.grt = 5'b00001;
        for (int i = 0; i < 5; i++) tick();
        chk("t3_drained", bus.olck, 2'b00);
        bus.grt = '0;

        // locked downstream VC blocks the head on VC0 while VC1 proceeds
        bus.ilck[2] = 1'b1;
        bus.grt = 5'b00010;
        send(1'b0, mk(2'b11, 3, 0, 32'h71));
        send(1'b1, mk(2'b11, 3, 0, 32'h72));
        tick();
        chk("t5_blocked", bus.req, 1'b0);
        tick();
        chk("t5_vc1_req", bus.req, 1'b1);
        tick();
        chk("t5_vc1_out", bus.ovch, 1'b1);
        chk("t5_vc1_ov", bus.ovalid, 1'b1);
        chk("t5_vc0_wait", bus.req, 1'b0);
        tick();
        chk("t5_vc0_wait2", bus.req, 1'b0);
        bus.ilck[2] = 1'b0;
        #1;
        chk("t5_vc0_req", bus.req, 1'b1);
        tick();
        chk("t5_vc0_out", bus.ovch, 1'b0);
        bus.grt = '0;
        tick();

        // reset in the middle of buffered packets
        send(1'b0, mk(2'b01, 1, 0, 32'h81));
        send(1'b0, mk(2'b00, 0, 0, 32'h82));
        send(1'b1, mk(2'b01, 1, 0, 32'h91));
        tick();
        bus.grt = 5'b00001;
        rst_ = 1'b0;
        tick();
        chk("t6_ordy", bus.ordy, 2'b11);
        chk("t6_olck", bus.olck, 2'b00);
        chk("t6_oack", bus.oack, 2'b00);
        chk("t6_ovalid", bus.ovalid, 1'b0);
        rst_ = 1'b1;
        tick();
        chk("t6_oack2", bus.oack, 2'b00);
        chk("t6_req", bus.req, 1'b0);
        bus.grt = '0;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
